dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port 256x32 data memory between the CPU MEM stage and an external debug/loader port. The CPU has priority. A debug requester is guaranteed service after STARVE_LIMIT contended cycles, and the CPU pipeline is stalled while a debug burst holds the memory. The block sits between the EX/MEM pipeline register outputs and data_mem. Its cpu_stall output feeds the pc/IF_ID write-enable and pipeline-freeze logic.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 32, data word width
STARVE_LIMIT, 4, max consecutive contended cycles a pending debug request waits (must be >=1)
LEN_W, 4, width of burst length field; burst = dbg_len+1 beats (1..16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_memread  in  1  MEM-stage read request
cpu_memwrite  in  1  MEM-stage write request
cpu_addr  in  ADDR_W  MEM-stage address
cpu_wdata  in  DATA_W  MEM-stage write data
cpu_rdata  out  DATA_W  read data to MEM/WB
cpu_stall  out  1  freeze pipeline; CPU holds request stable while high
dbg_req  in  1  debug burst request (level)
dbg_we  in  1  1=write burst, 0=read burst; sampled at grant
dbg_addr  in  ADDR_W  burst start address; sampled at grant
dbg_len  in  LEN_W  beats minus one; sampled at grant
dbg_wdata  in  DATA_W  write data, consumed in every cycle dbg_beat=1
dbg_gnt  out  1  one-cycle pulse, first burst cycle
dbg_beat  out  1  high each cycle a debug beat accesses memory
dbg_done  out  1  high during last beat cycle
dbg_rdata  out  DATA_W  registered read data
dbg_rvalid  out  1  dbg_rdata valid (one cycle after each read beat)
mem_re  out  1  to data_mem MEM_memread
mem_we  out  1  to data_mem MEM_memwrite
mem_addr  out  ADDR_W  to data_mem addr
mem_wdata  out  DATA_W  to data_mem wdata
mem_rdata  in  DATA_W  from data_mem rdata (combinational read)

Behaviour:
- Reset (reset=0, async):
  - State goes to S_CPU; starve_cnt, addr_q, beats_left, we_q are 0.
  - dbg_gnt, dbg_beat, dbg_done, dbg_rvalid, cpu_stall are 0; dbg_rdata is 0.
  - mem_re and mem_we are forced to 0 while reset is low.
- FSM states: S_CPU, S_DBG, S_GAP.
- cpu_acc = cpu_memread | cpu_memwrite. If both are high, the write wins: mem_we=1, mem_re=0.
- S_CPU:
  - mem_* is driven combinationally from cpu_*; cpu_rdata = mem_rdata; cpu_stall = 0.
  - grant = dbg_req & (~cpu_acc | starve_cnt == STARVE_LIMIT-1).
  - starve_cnt increments when dbg_req & cpu_acc & ~grant. It clears on grant or when dbg_req=0. It saturates at STARVE_LIMIT-1.
  - On grant: latch dbg_addr->addr_q, dbg_we->we_q, dbg_len->beats_left, then go to S_DBG. The CPU access in the grant cycle completes normally.
- S_DBG, one beat per cycle:
  - mem_addr = addr_q; mem_we = we_q; mem_re = ~we_q; mem_wdata = dbg_wdata; dbg_beat = 1.
  - dbg_gnt = 1 only in the first S_DBG cycle (registered).
  - addr_q increments modulo 2^ADDR_W (0xFF wraps to 0x00); beats_left decrements.
  - beats_left==0: dbg_done=1 and the next state is S_GAP.
  - cpu_stall = cpu_acc (combinational); cpu_rdata = 0.
  - dbg_req changes are ignored until the FSM is back in S_CPU.
- Read beats: dbg_rdata <= mem_rdata and dbg_rvalid <= 1 on the next edge. The final rvalid appears in the S_GAP cycle.
- S_GAP: exactly one cycle. The CPU owns the memory as in S_CPU, but a grant is forbidden and starve_cnt is 0. Next state is S_CPU. This prevents back-to-back bursts from starving the CPU.
- Debug latency with the CPU idle:
  - dbg_req sampled high at edge N; beats occupy cycles N+1..N+1+dbg_len.
  - For reads, rvalid occupies cycles N+2..N+2+dbg_len.
- Worst-case debug wait under continuous CPU traffic is STARVE_LIMIT cycles. Worst-case CPU stall is LEN max+1 = 16 cycles per burst.
- Reset mid-burst: the burst is abandoned; no dbg_done and no further rvalid. Memory writes already performed remain.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {S_CPU, S_DBG, S_GAP};
  - default ADDR_W, DATA_W, LEN_W constants.
- Sub-module dbg_burst_ctr: holds addr_q/beats_left/we_q with load, step, last outputs. The FSM, mux and starvation counter stay in dmem_arbiter.

Test Plan:
- CPU only: cpu_memwrite addr 0x10 data 0xDEADBEEF, then cpu_memread 0x10 -> mem_we pass-through, cpu_rdata=0xDEADBEEF, cpu_stall never 1.
- Idle CPU, debug write burst: addr 0xFE, len 3, wdata 1,2,3,4 -> dbg_gnt 1 cycle after req; memory 0xFE=1, 0xFF=2, 0x00=3, 0x01=4 (wrap); dbg_done on 4th beat; S_GAP one cycle.
- Debug read burst of the same 4 words -> dbg_rvalid 4 consecutive cycles starting 1 cycle after the first beat, dbg_rdata 1,2,3,4.
- Starvation: cpu_memread continuously high, dbg_req high -> grant after exactly STARVE_LIMIT=4 contended cycles; cpu_stall high for every S_DBG cycle; CPU read completes correctly after S_GAP.
- Back-to-back: dbg_req held high with a continuous CPU stream -> at least one S_GAP CPU access between bursts; cpu_stall low in S_GAP.
- Async reset asserted on the 2nd beat of a len=7 burst -> outputs 0 immediately; state S_CPU; no dbg_done; next CPU access is served normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF       = 8;
    localparam int DATA_W_DEF       = 32;
    localparam int LEN_W_DEF        = 4;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_DBG = 2'd1,
        S_GAP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dbg_burst_ctr.sv
// Debug burst bookkeeping: current beat address, beats remaining and direction.
module dbg_burst_ctr #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  beats_left_q;
    logic              we_q;

    // Latch burst parameters at grant; advance one beat per step (address wraps naturally).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            beats_left_q <= '0;
            we_q         <= 1'b0;
        end else if (load_i) begin
            addr_q       <= addr_i;
            beats_left_q <= len_i;
            we_q         <= we_i;
        end else if (step_i) begin
            addr_q <= addr_q + 1'b1;
            if (beats_left_q != '0) begin
                beats_left_q <= beats_left_q - 1'b1;
            end
        end
    end

    assign addr_o = addr_q;
    assign we_o   = we_q;
    assign last_o = (beats_left_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage has priority, debug bursts
// are granted when the CPU is idle or after the starvation limit.
//
//   state | meaning
//   S_CPU | CPU owns memory; debug request may be granted
//   S_DBG | debug burst beat each cycle; CPU stalled if it wants memory
//   S_GAP | one guaranteed CPU cycle after a burst; no grant allowed
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int LEN_W        = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [LEN_W-1:0]  dbg_len,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_beat,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              gnt_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              cpu_acc;
    logic              grant;
    logic              step;
    logic              mem_re_raw;
    logic              mem_we_raw;
    logic [ADDR_W-1:0] burst_addr;
    logic              burst_we;
    logic              burst_last;

    assign cpu_acc = cpu_memread | cpu_memwrite;

    dbg_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst (
        .clk    (clk),
        .reset  (reset),
        .load_i (grant),
        .step_i (step),
        .addr_i (dbg_addr),
        .we_i   (dbg_we),
        .len_i  (dbg_len),
        .addr_o (burst_addr),
        .we_o   (burst_we),
        .last_o (burst_last)
    );

    // Next state, starvation count and the memory/CPU/debug output mux.
    always_comb begin
        state_d    = state_q;
        starve_d   = '0;
        grant      = 1'b0;
        step       = 1'b0;
        mem_re_raw = cpu_memread & ~cpu_memwrite;
        mem_we_raw = cpu_memwrite;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_rdata  = mem_rdata;
        cpu_stall  = 1'b0;
        dbg_beat   = 1'b0;
        dbg_done   = 1'b0;
        case (state_q)
            S_CPU: begin
                grant = dbg_req & (~cpu_acc | (starve_q == STARVE_MAX));
                if (grant) begin
                    state_d = S_DBG;
                end else if (dbg_req & cpu_acc) begin
                    starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
                end
            end
            S_DBG: begin
                mem_re_raw = ~burst_we;
                mem_we_raw = burst_we;
                mem_addr   = burst_addr;
                mem_wdata  = dbg_wdata;
                cpu_rdata  = '0;
                cpu_stall  = cpu_acc;
                dbg_beat   = 1'b1;
                step       = 1'b1;
                if (burst_last) begin
                    dbg_done = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_CPU;
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    // Memory strobes are held off for as long as reset is asserted.
    assign mem_re = mem_re_raw & reset;
    assign mem_we = mem_we_raw & reset;

    // State, starvation counter, grant pulse and registered debug read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CPU;
            starve_q <= '0;
            gnt_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            gnt_q    <= grant;
            rvalid_q <= dbg_beat & ~burst_we;
            if (dbg_beat & ~burst_we) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign dbg_gnt    = gnt_q;
    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memread, cpu_memwrite;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [3:0]  dbg_len;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        dbg_gnt, dbg_beat, dbg_done, dbg_rvalid;
    logic        mem_re, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(SL), .LEN_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_beat(dbg_beat), .dbg_done(dbg_done),
        .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, synchronous write
    logic [31:0] dut_mem [256];
    logic        clear_mem;
    assign mem_rdata = dut_mem[mem_addr];
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) dut_mem[i] <= 32'h0;
        end else if (mem_we) begin
            dut_mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model state (ownership described by beats remaining / gap / wait count)
    logic [31:0] ref_mem [256];
    int          m_rem, m_wait;
    bit          m_gap, m_first, m_we;
    logic [7:0]  m_addr;
    bit          p_rv;
    logic [31:0] p_rd;

    int total = 0;
    int bad = 0;

    logic        o_gnt, o_beat, o_done, o_stall, o_rv, o_mem_we;
    logic [31:0] o_rd, o_cpu_rd;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } cpu_vec_t;
    cpu_vec_t vec [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic reset_model();
        m_rem = 0; m_wait = 0; m_gap = 0; m_first = 0; p_rv = 0;
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then advance the model.
    task automatic cyc();
        bit acc, dbg, grant;
        @(negedge clk);
        acc   = cpu_memread | cpu_memwrite;
        dbg   = (m_rem > 0);
        grant = !dbg && !m_gap && dbg_req && (!acc || m_wait == SL - 1);
        o_gnt = dbg_gnt; o_beat = dbg_beat; o_done = dbg_done; o_stall = cpu_stall;
        o_rv = dbg_rvalid; o_rd = dbg_rdata; o_cpu_rd = cpu_rdata; o_mem_we = mem_we;
        chk1("beat", dbg_beat, dbg);
        chk1("gnt", dbg_gnt, dbg && m_first);
        chk1("done", dbg_done, dbg && m_rem == 1);
        chk1("stall", cpu_stall, dbg && acc);
        chk1("rvalid", dbg_rvalid, p_rv);
        if (p_rv) chk("dbg_rdata", dbg_rdata, p_rd);
        if (dbg) begin
            chk("dbg_mem_addr", 32'(mem_addr), 32'(m_addr));
            chk1("dbg_mem_we", mem_we, m_we);
            chk1("dbg_mem_re", mem_re, !m_we);
            chk("dbg_cpu_rdata", cpu_rdata, 32'h0);
            if (m_we) chk("dbg_mem_wdata", mem_wdata, dbg_wdata);
        end else begin
            chk1("cpu_mem_we", mem_we, cpu_memwrite);
            chk1("cpu_mem_re", mem_re, cpu_memread && !cpu_memwrite);
            if (acc) chk("cpu_mem_addr", 32'(mem_addr), 32'(cpu_addr));
            if (cpu_memwrite) chk("cpu_mem_wdata", mem_wdata, cpu_wdata);
            if (cpu_memread && !cpu_memwrite) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
        end
        @(posedge clk);
        if (dbg) begin
            if (m_we) begin
                ref_mem[m_addr] = dbg_wdata;
                p_rv = 0;
            end else begin
                p_rv = 1;
                p_rd = ref_mem[m_addr];
            end
            m_addr  = m_addr + 8'd1;
            m_rem   = m_rem - 1;
            m_first = 0;
            m_wait  = 0;
            if (m_rem == 0) m_gap = 1;
        end else begin
            p_rv = 0;
            if (cpu_memwrite) ref_mem[cpu_addr] = cpu_wdata;
            if (m_gap) begin
                m_gap = 0; m_wait = 0;
            end else if (grant) begin
                m_rem = int'(dbg_len) + 1; m_addr = dbg_addr; m_we = dbg_we;
                m_first = 1; m_wait = 0;
            end else if (dbg_req && acc) begin
                m_wait = (m_wait < SL - 1) ? m_wait + 1 : m_wait;
            end else begin
                m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic flush();
        for (int k = 0; k < 40 && (m_rem > 0 || m_gap || p_rv); k++) cyc();
        chk1("flush_idle", (m_rem > 0 || m_gap || p_rv), 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gnt_cyc, stall_n, rv_n, rv_first, n_gnt, diff, r;
        bit prev_done, seen_done;
        logic [31:0] got [4];

        reset = 1'b0; clear_mem = 1'b1;
        cpu_memread = 1'b1; cpu_memwrite = 1'b1; cpu_addr = 8'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h0; dbg_len = 4'h0; dbg_wdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_gnt", dbg_gnt, 1'b0);
        chk1("rst_beat", dbg_beat, 1'b0);
        chk1("rst_done", dbg_done, 1'b0);
        chk1("rst_rvalid", dbg_rvalid, 1'b0);
        chk1("rst_stall", cpu_stall, 1'b0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        cpu_memread = 1'b0; cpu_memwrite = 1'b0; clear_mem = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        // CPU-only table
        vec[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
        vec[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vec[2] = '{1'b0, 1'b1, 8'h11, 32'h12345678, 32'h0};
        vec[3] = '{1'b1, 1'b1, 8'h12, 32'hA5A5A5A5, 32'h0};
        vec[4] = '{1'b1, 1'b0, 8'h11, 32'h0,        32'h12345678};
        vec[5] = '{1'b1, 1'b0, 8'h12, 32'h0,        32'hA5A5A5A5};
        vec[6] = '{1'b1, 1'b0, 8'h13, 32'h0,        32'h0};
        vec[7] = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        for (int i = 0; i < 8; i++) begin
            cpu_memread = vec[i].rd; cpu_memwrite = vec[i].wr;
            cpu_addr = vec[i].addr; cpu_wdata = vec[i].wdata;
            cyc();
            chk1("tbl_stall", o_stall, 1'b0);
            if (vec[i].wr) chk1("tbl_mem_we", o_mem_we, 1'b1);
            else chk("tbl_rdata", o_cpu_rd, vec[i].exp_rdata);
        end
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;

        // Debug write burst with address wrap, CPU idle
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'hFE; dbg_len = 4'd3;
        cyc();
        chk1("wr_gnt_early", o_gnt, 1'b0);
        dbg_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dbg_wdata = 32'(i + 1);
            cyc();
            chk1("wr_beat", o_beat, 1'b1);
            chk1("wr_gnt", o_gnt, i == 0);
            chk1("wr_done", o_done, i == 3);
        end
        cyc();
        chk1("wr_gap_beat", o_beat, 1'b0);
        chk("wr_mem_fe", dut_mem[8'hFE], 32'd1);
        chk("wr_mem_ff", dut_mem[8'hFF], 32'd2);
        chk("wr_mem_00", dut_mem[8'h00], 32'd3);
        chk("wr_mem_01", dut_mem[8'h01], 32'd4);

        // Debug read burst of the same words
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'hFE; dbg_len = 4'd3;
        cyc();
        dbg_req = 1'b0;
        rv_n = 0; rv_first = -1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (o_rv) begin
                if (rv_first < 0) rv_first = c;
                if (rv_n < 4) got[rv_n] = o_rd;
                rv_n++;
            end
        end
        chk("rd_rv_count", 32'(rv_n), 32'd4);
        chk("rd_rv_first", 32'(rv_first), 32'd1);
        for (int i = 0; i < 4; i++) chk("rd_data", got[i], 32'(i + 1));

        // Starvation: continuous CPU reads against a pending debug write
        cpu_memread = 1'b1; cpu_addr = 8'h11;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h80; dbg_len = 4'd2; dbg_wdata = 32'h55;
        gnt_cyc = -1;
        for (int c = 0; c < 20 && gnt_cyc < 0; c++) begin
            cyc();
            if (o_gnt) gnt_cyc = c;
        end
        chk("starve_gnt_cycle", 32'(gnt_cyc), 32'(SL));
        dbg_req = 1'b0;
        stall_n = o_stall ? 1 : 0;
        seen_done = o_done;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            cyc();
            if (o_stall) stall_n++;
            seen_done = o_done;
        end
        chk1("starve_done_seen", seen_done, 1'b1);
        chk("starve_stall_cycles", 32'(stall_n), 32'd3);
        cyc();
        chk1("starve_gap_stall", o_stall, 1'b0);
        chk("starve_gap_rdata", o_cpu_rd, 32'h12345678);

        // Back-to-back requests under a continuous CPU stream
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h11; dbg_len = 4'd1;
        n_gnt = 0; prev_done = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (o_gnt) n_gnt++;
            if (prev_done) begin
                chk1("b2b_gap_beat", o_beat, 1'b0);
                chk1("b2b_gap_stall", o_stall, 1'b0);
            end
            prev_done = o_done;
        end
        chk1("b2b_bursts", n_gnt >= 2, 1'b1);
        dbg_req = 1'b0; cpu_memread = 1'b0;
        flush();

        // Reset asserted during the second beat of a len=7 write burst
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_len = 4'd7;
        cyc();
        dbg_req = 1'b0; dbg_wdata = 32'h111;
        cyc();
        dbg_wdata = 32'h222;
        #2 reset = 1'b0;
        #1;
        chk1("mid_rst_beat", dbg_beat, 1'b0);
        chk1("mid_rst_done", dbg_done, 1'b0);
        chk1("mid_rst_gnt", dbg_gnt, 1'b0);
        chk1("mid_rst_stall", cpu_stall, 1'b0);
        chk1("mid_rst_mem_we", mem_we, 1'b0);
        chk1("mid_rst_rvalid", dbg_rvalid, 1'b0);
        reset_model();
        @(posedge clk); #1 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk1("post_rst_done", o_done, 1'b0);
        end
        cpu_memread = 1'b1; cpu_addr = 8'h40;
        cyc();
        chk("post_rst_rd40", o_cpu_rd, 32'h111);
        cpu_addr = 8'h41;
        cyc();
        chk("post_rst_rd41", o_cpu_rd, 32'h0);
        cpu_memread = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if (!(m_rem > 0 && (cpu_memread || cpu_memwrite))) begin
                r = int'($urandom_range(0, 3));
                cpu_memread  = (r == 1 || r == 3);
                cpu_memwrite = (r >= 2);
                cpu_addr  = 8'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!(dbg_req && m_rem == 0)) begin
                dbg_req  = ($urandom_range(0, 4) == 0);
                dbg_we   = 1'($urandom_range(0, 1));
                dbg_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                       : 8'($urandom_range(240, 255));
                dbg_len  = 4'($urandom_range(0, 5));
            end
            dbg_wdata = $urandom;
            cyc();
        end
        cpu_memread = 1'b0; cpu_memwrite = 1'b0; dbg_req = 1'b0;
        flush();

        diff = 0;
        for (int i = 0; i < 256; i++) if (dut_mem[i] !== ref_mem[i]) diff++;
        chk("mem_image_diffs", 32'(diff), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
